// File: rtl/input_stream_rom.sv
// Byte-stream loaded ROM: accepts a valid/ready byte stream, then serves core reads.
// Read latency 1 cycle; in_ready drops outside LOAD or once the store is full.
module input_stream_rom #(
  parameter int N_ADDR_BITS = 16,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  reload,
  input  logic [N_ADDR_BITS:0]  addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  loaded,
  output logic [N_ADDR_BITS:0]  length,
  output logic                  truncated
);

  typedef enum logic {LOAD, SERVE} state_e;

  localparam logic [N_ADDR_BITS:0] DEPTH = {1'b1, {N_ADDR_BITS{1'b0}}};
  localparam logic [N_ADDR_BITS:0] ONE   = {{N_ADDR_BITS{1'b0}}, 1'b1};

  state_e                 state_q;
  logic [N_ADDR_BITS:0]   length_q;
  logic [N_ADDR_BITS:0]   length_d;
  logic                   loaded_q;
  logic                   truncated_q;
  logic                   valid_q;
  logic [DATA_WIDTH-1:0]  rd_q;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  mem [0:(1<<N_ADDR_BITS)-1];

  assign in_ready = (state_q == LOAD) && (length_q < DEPTH);
  // reload takes priority: a byte offered in the same cycle is dropped
  assign accept   = in_valid && in_ready && !reload;
  assign length_d = length_q + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      length_q    <= '0;
      loaded_q    <= 1'b0;
      truncated_q <= 1'b0;
      valid_q     <= 1'b0;
    end else if (reload) begin
      state_q     <= LOAD;
      length_q    <= '0;
      loaded_q    <= 1'b0;
      truncated_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= (state_q == SERVE) && (addr < length_q);
      if (accept) begin
        length_q <= length_d;
        if (in_last) begin
          state_q  <= SERVE;
          loaded_q <= 1'b1;
        end else if (length_d == DEPTH) begin
          state_q     <= SERVE;
          loaded_q    <= 1'b1;
          truncated_q <= 1'b1;
        end
      end
    end
  end

  // No reset on the storage so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[length_q[N_ADDR_BITS-1:0]] <= in_data;
    end
    if (state_q == SERVE) begin
      rd_q <= mem[addr[N_ADDR_BITS-1:0]];
    end
  end

  assign data_out  = valid_q ? rd_q : '0;
  assign valid     = valid_q;
  assign loaded    = loaded_q;
  assign length    = length_q;
  assign truncated = truncated_q;

endmodule

// File: tb/tb_input_stream_rom.sv
// Directed bench for input_stream_rom at depth 16: vector table plus overflow/fit/reset sequences.
module tb_input_stream_rom;

  localparam int NA = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       reload;
  logic [4:0] addr;
  logic [7:0] data_out;
  logic       valid;
  logic       loaded;
  logic [4:0] length;
  logic       truncated;

  int checks = 0;
  int errors = 0;

  input_stream_rom #(.N_ADDR_BITS(NA), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .reload(reload), .addr(addr),
    .data_out(data_out), .valid(valid), .loaded(loaded),
    .length(length), .truncated(truncated)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       last;
    logic       rl;
    logic [4:0] a;
    logic       rdy;
    logic       ld;
    logic [4:0] len;
    logic       tr;
    logic       vl;
    logic [7:0] dout;
  } vec_t;

  vec_t vec [19];

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic ld,
                           input logic [4:0] len, input logic tr,
                           input logic vl, input logic [7:0] dout);
    cmp({tag, ".in_ready"},  int'(in_ready),  int'(rdy));
    cmp({tag, ".loaded"},    int'(loaded),    int'(ld));
    cmp({tag, ".length"},    int'(length),    int'(len));
    cmp({tag, ".truncated"}, int'(truncated), int'(tr));
    cmp({tag, ".valid"},     int'(valid),     int'(vl));
    cmp({tag, ".data_out"},  int'(data_out),  int'(dout));
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge
  task automatic step(input logic v, input logic [7:0] d, input logic last,
                      input logic rl, input logic [4:0] a);
    in_valid = v;
    in_data  = d;
    in_last  = last;
    reload   = rl;
    addr     = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; reload = 1'b0; addr = '0;

    //           v  d      last rl a      rdy ld len tr vl dout
    vec[0]  = '{1, 8'h4C, 0, 0, 5'd0,  1, 0, 1, 0, 0, 8'h00};  // 'L'
    vec[1]  = '{1, 8'h36, 0, 0, 5'd0,  1, 0, 2, 0, 0, 8'h00};  // '6'
    vec[2]  = '{1, 8'h38, 0, 0, 5'd0,  1, 0, 3, 0, 0, 8'h00};  // '8'
    vec[3]  = '{1, 8'h0A, 1, 0, 5'd0,  0, 1, 4, 0, 0, 8'h00};  // '\n' last
    vec[4]  = '{0, 8'h00, 0, 0, 5'd0,  0, 1, 4, 0, 1, 8'h4C};
    vec[5]  = '{0, 8'h00, 0, 0, 5'd1,  0, 1, 4, 0, 1, 8'h36};
    vec[6]  = '{0, 8'h00, 0, 0, 5'd2,  0, 1, 4, 0, 1, 8'h38};
    vec[7]  = '{0, 8'h00, 0, 0, 5'd3,  0, 1, 4, 0, 1, 8'h0A};
    vec[8]  = '{0, 8'h00, 0, 0, 5'd4,  0, 1, 4, 0, 0, 8'h00};
    vec[9]  = '{0, 8'h00, 0, 0, 5'd5,  0, 1, 4, 0, 0, 8'h00};
    vec[10] = '{0, 8'h00, 0, 0, 5'd16, 0, 1, 4, 0, 0, 8'h00};
    vec[11] = '{1, 8'h5A, 0, 1, 5'd0,  1, 0, 0, 0, 0, 8'h00};  // reload in SERVE
    vec[12] = '{1, 8'h41, 0, 0, 5'd0,  1, 0, 1, 0, 0, 8'h00};  // 'A'
    vec[13] = '{1, 8'h42, 0, 1, 5'd0,  1, 0, 0, 0, 0, 8'h00};  // 'B' dropped by reload
    vec[14] = '{1, 8'h52, 0, 0, 5'd0,  1, 0, 1, 0, 0, 8'h00};  // 'R'
    vec[15] = '{1, 8'h35, 1, 0, 5'd0,  0, 1, 2, 0, 0, 8'h00};  // '5' last
    vec[16] = '{0, 8'h00, 0, 0, 5'd0,  0, 1, 2, 0, 1, 8'h52};
    vec[17] = '{0, 8'h00, 0, 0, 5'd1,  0, 1, 2, 0, 1, 8'h35};
    vec[18] = '{0, 8'h00, 0, 0, 5'd2,  0, 1, 2, 0, 0, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1, 0, 0, 0, 0, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(vec[i].v, vec[i].d, vec[i].last, vec[i].rl, vec[i].a);
      check_all($sformatf("vec%0d", i), vec[i].rdy, vec[i].ld, vec[i].len,
                vec[i].tr, vec[i].vl, vec[i].dout);
    end

    // Overflow: 20 bytes without last, only 16 stored
    step(0, 8'h00, 0, 1, 5'd0);
    check_all("ovf.reload", 1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      logic vl_e;
      vl_e = (i >= 16);
      step(1, 8'(8'h30 + i), 0, 0, 5'd15);
      check_all($sformatf("ovf%0d", i), i < 15, i >= 15, 5'(i >= 15 ? 16 : i + 1),
                i >= 15, vl_e, vl_e ? 8'h3F : 8'h00);
    end
    step(0, 8'h00, 0, 0, 5'd16);
    check_all("ovf.addr16", 0, 1, 16, 1, 0, 8'h00);
    step(0, 8'h00, 0, 0, 5'd0);
    check_all("ovf.addr0", 0, 1, 16, 1, 1, 8'h30);

    // Exact fit: last arrives on the 16th byte
    step(0, 8'h00, 0, 1, 5'd0);
    check_all("fit.reload", 1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(8'h40 + i), i == 15, 0, 5'd15);
      check_all($sformatf("fit%0d", i), i < 15, i == 15, 5'(i + 1), 0, 0, 8'h00);
    end
    step(0, 8'h00, 0, 0, 5'd15);
    check_all("fit.addr15", 0, 1, 16, 0, 1, 8'h4F);
    step(0, 8'h00, 0, 0, 5'd16);
    check_all("fit.addr16", 0, 1, 16, 0, 0, 8'h00);

    // Reset mid-load: outputs must clear before any clock edge
    step(0, 8'h00, 0, 1, 5'd0);
    step(1, 8'h61, 0, 0, 5'd0);
    step(1, 8'h62, 0, 0, 5'd0);
    step(1, 8'h63, 0, 0, 5'd0);
    check_all("mid.pre", 1, 0, 3, 0, 0, 8'h00);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all("mid.async", 1, 0, 0, 0, 0, 8'h00);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 8'h58, 1, 0, 5'd0);
    check_all("mid.X", 0, 1, 1, 0, 0, 8'h00);
    step(0, 8'h00, 0, 0, 5'd0);
    check_all("mid.addr0", 0, 1, 1, 0, 1, 8'h58);
    step(0, 8'h00, 0, 0, 5'd1);
    check_all("mid.addr1", 0, 1, 1, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
